// File: rtl/pagerank_mem_arbiter.sv
// Two-requester round-robin arbiter for one memory port.
// Requests are granted with a per-transfer lock; responses are steered in order via an ID FIFO.
module pagerank_mem_arbiter #(
    parameter int p_max_outstanding = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [76:0]             req0_msg,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    output logic [46:0]             resp0_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,

    input  logic [76:0]             req1_msg,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    output logic [46:0]             resp1_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,

    output logic [76:0]             mem_req_msg,
    output logic                    mem_req_val,
    input  logic                    mem_req_rdy,
    input  logic [46:0]             mem_resp_msg,
    input  logic                    mem_resp_val,
    output logic                    mem_resp_rdy,

    output logic [$clog2(p_max_outstanding+1)-1:0] outstanding,
    output logic                    err_spurious
);

    localparam int CW = $clog2(p_max_outstanding + 1);
    localparam int AW = $clog2(p_max_outstanding);
    localparam logic [CW-1:0] MAX_CNT = CW'(p_max_outstanding);

    logic          id_fifo [p_max_outstanding];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rr_ptr;
    logic          lock;
    logic          lock_id;

    logic full;
    logic nonempty;
    logic elig0;
    logic elig1;
    logic grant_vld;
    logic grant_id;
    logic sel_val;
    logic req_fire;
    logic head;
    logic resp_fire;

    assign full     = (count == MAX_CNT);
    assign nonempty = (count != '0);
    assign elig0    = req0_val & ~full;
    assign elig1    = req1_val & ~full;
    assign head     = id_fifo[rd_ptr];

    // Grant selection: a stalled transfer keeps its grant, otherwise round-robin
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (lock) begin
            grant_vld = 1'b1;
            grant_id  = lock_id;
        end else if (rr_ptr == 1'b0) begin
            if (elig0) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (elig1) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end else begin
            if (elig1) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end else if (elig0) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end
        end
    end

    // Request-side pass-through of the granted requester, forced quiet in reset
    always_comb begin
        sel_val     = grant_id ? req1_val : req0_val;
        mem_req_val = grant_vld & sel_val & ~full & ~reset;
        mem_req_msg = '0;
        if (grant_vld && !reset)
            mem_req_msg = grant_id ? req1_msg : req0_msg;
        req0_rdy = grant_vld & ~grant_id & mem_req_rdy & ~full & ~reset;
        req1_rdy = grant_vld &  grant_id & mem_req_rdy & ~full & ~reset;
        req_fire = mem_req_val & mem_req_rdy;
    end

    // Response steering to the requester at the head of the ID FIFO
    always_comb begin
        resp0_msg    = reset ? '0 : mem_resp_msg;
        resp1_msg    = reset ? '0 : mem_resp_msg;
        resp0_val    = mem_resp_val & nonempty & ~head & ~reset;
        resp1_val    = mem_resp_val & nonempty &  head & ~reset;
        mem_resp_rdy = nonempty & (head ? resp1_rdy : resp0_rdy) & ~reset;
        resp_fire    = mem_resp_val & mem_resp_rdy;
    end

    // ID FIFO, round-robin pointer, grant lock and spurious-response flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < p_max_outstanding; i++)
                id_fifo[i] <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rr_ptr       <= 1'b0;
            lock         <= 1'b0;
            lock_id      <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (req_fire) begin
                id_fifo[wr_ptr] <= grant_id;
                wr_ptr          <= wr_ptr + 1'b1;
                rr_ptr          <= ~grant_id;
                lock            <= 1'b0;
            end else if (mem_req_val) begin
                lock    <= 1'b1;
                lock_id <= grant_id;
            end
            if (resp_fire)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(req_fire) - CW'(resp_fire);
            if (mem_resp_val && !nonempty)
                err_spurious <= 1'b1;
        end
    end

    assign outstanding = count;

endmodule

// File: tb/tb_pagerank_mem_arbiter.sv
// Random-traffic bench for pagerank_mem_arbiter.
// Compares the DUT against a transaction-level model of grants, ordering and routing.
module tb_pagerank_mem_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [76:0] rmsg [2];
    logic        rval [2];
    logic        rrdy [2];
    logic [46:0] pmsg [2];
    logic        pval [2];
    logic        prdy [2];
    logic [76:0] mem_req_msg;
    logic        mem_req_val;
    logic        mem_req_rdy;
    logic [46:0] mem_resp_msg;
    logic        mem_resp_val;
    logic        mem_resp_rdy;
    logic [2:0]  outstanding;
    logic        err_spurious;

    int n_chk = 0;
    int n_err = 0;

    // model state
    int          ids [$];
    logic [46:0] memq [$];
    logic [46:0] exp_resp0 [$];
    logic [46:0] exp_resp1 [$];
    bit          fav;
    bit          held;
    bit          held_id;
    bit          exp_err;
    bit          fired [2];

    always #5 clk = ~clk;

    pagerank_mem_arbiter #(.p_max_outstanding(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_msg     (rmsg[0]),
        .req0_val     (rval[0]),
        .req0_rdy     (rrdy[0]),
        .resp0_msg    (pmsg[0]),
        .resp0_val    (pval[0]),
        .resp0_rdy    (prdy[0]),
        .req1_msg     (rmsg[1]),
        .req1_val     (rval[1]),
        .req1_rdy     (rrdy[1]),
        .resp1_msg    (pmsg[1]),
        .resp1_val    (pval[1]),
        .resp1_rdy    (prdy[1]),
        .mem_req_msg  (mem_req_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_msg (mem_resp_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .outstanding  (outstanding),
        .err_spurious (err_spurious)
    );

    task automatic chk(input string tag, input logic [76:0] got, input logic [76:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [46:0] mem_of(input logic [76:0] m);
        return m[46:0] ^ {m[76:62], 32'hC0DE_F00D};
    endfunction

    function automatic logic [76:0] rand77();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        ids.delete();
        memq.delete();
        exp_resp0.delete();
        exp_resp1.delete();
        fav     = 1'b0;
        held    = 1'b0;
        held_id = 1'b0;
        exp_err = 1'b0;
        for (int n = 0; n < 2; n++) begin
            fired[n] = 1'b0;
            rval[n]  = 1'b0;
            rmsg[n]  = '0;
            prdy[n]  = 1'b0;
        end
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;
    endtask

    // One clock cycle: drive, predict, compare, advance the model.
    task automatic step(input int req_p, input int mrdy_p, input int resp_p,
                        input int rrdy_p, input bit spur);
        bit          full;
        bit          gv;
        bit          g;
        bit          ev;
        bit          ne;
        bit          hd;
        bit          emrr;
        logic [46:0] er;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            if (fired[n]) rval[n] = 1'b0;
            fired[n] = 1'b0;
            if (!rval[n] && $urandom_range(99) < req_p) begin
                rval[n] = 1'b1;
                rmsg[n] = rand77();
            end
            prdy[n] = ($urandom_range(99) < rrdy_p);
        end
        mem_req_rdy = ($urandom_range(99) < mrdy_p);
        if (memq.size() > 0) begin
            mem_resp_val = ($urandom_range(99) < resp_p);
            mem_resp_msg = memq[0];
        end else begin
            mem_resp_val = spur;
            mem_resp_msg = rand77();
        end
        #1;
        full = (ids.size() == DEPTH);
        gv = 1'b0;
        g  = 1'b0;
        if (held) begin
            gv = 1'b1;
            g  = held_id;
        end else if (!full) begin
            if (rval[fav]) begin
                gv = 1'b1;
                g  = fav;
            end else if (rval[!fav]) begin
                gv = 1'b1;
                g  = !fav;
            end
        end
        ev = gv && rval[g] && !full;
        chk("mem_req_val", mem_req_val, ev);
        chk("mem_req_msg", mem_req_msg, gv ? rmsg[g] : 77'd0);
        chk("req0_rdy", rrdy[0], gv && g == 0 && mem_req_rdy && !full);
        chk("req1_rdy", rrdy[1], gv && g == 1 && mem_req_rdy && !full);
        ne   = (ids.size() > 0);
        hd   = ne ? ids[0][0] : 1'b0;
        emrr = ne && prdy[hd];
        chk("resp0_val", pval[0], mem_resp_val && ne && hd == 0);
        chk("resp1_val", pval[1], mem_resp_val && ne && hd == 1);
        chk("mem_resp_rdy", mem_resp_rdy, emrr);
        chk("outstanding", outstanding, ids.size());
        chk("err_spurious", err_spurious, exp_err);
        if (mem_resp_val && emrr) begin
            if (hd == 0) begin
                er = exp_resp0.pop_front();
                chk("resp0_data", pmsg[0], er);
            end else begin
                er = exp_resp1.pop_front();
                chk("resp1_data", pmsg[1], er);
            end
            void'(ids.pop_front());
            void'(memq.pop_front());
        end
        if (mem_resp_val && !ne) exp_err = 1'b1;
        if (ev) begin
            if (mem_req_rdy) begin
                ids.push_back(int'(g));
                memq.push_back(mem_of(rmsg[g]));
                if (g == 0) exp_resp0.push_back(mem_of(rmsg[g]));
                else        exp_resp1.push_back(mem_of(rmsg[g]));
                fav      = !g;
                held     = 1'b0;
                fired[g] = 1'b1;
            end else begin
                held    = 1'b1;
                held_id = g;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req_val"}, mem_req_val, 1'b0);
        chk({tag, "_mem_req_msg"}, mem_req_msg, 77'd0);
        chk({tag, "_req0_rdy"}, rrdy[0], 1'b0);
        chk({tag, "_req1_rdy"}, rrdy[1], 1'b0);
        chk({tag, "_resp0_val"}, pval[0], 1'b0);
        chk({tag, "_resp1_val"}, pval[1], 1'b0);
        chk({tag, "_mem_resp_rdy"}, mem_resp_rdy, 1'b0);
        chk({tag, "_outstanding"}, outstanding, 3'd0);
        chk({tag, "_err"}, err_spurious, 1'b0);
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        model_clear();
        #1;
        check_all_zero("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // slow memory: fills the ID FIFO and exercises the full stall
        repeat (300) step(80, 70, 10, 70, 1'b0);
        // fast memory, heavy contention
        repeat (300) step(100, 100, 90, 90, 1'b0);
        // memory back-pressure to exercise the lock
        repeat (200) step(70, 30, 60, 60, 1'b0);

        // drain, then a spurious response
        guard = 0;
        while (ids.size() > 0 && guard < 100) begin
            step(0, 100, 100, 100, 1'b0);
            guard++;
        end
        chk("drain_done", ids.size() == 0, 1'b1);
        for (int n = 0; n < 2; n++) fired[n] = 1'b0;
        step(0, 100, 100, 100, 1'b1);
        repeat (5) step(0, 100, 100, 100, 1'b0);
        chk("err_sticky", err_spurious, 1'b1);

        // asynchronous reset in the middle of a burst
        repeat (40) step(90, 60, 30, 70, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_val", mem_req_val, 1'b0);
        chk("async_rst_cnt", outstanding, 3'd0);
        chk("async_rst_err", err_spurious, 1'b0);
        @(negedge clk);
        model_clear();
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (300) step(75, 60, 50, 70, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
